// File: rtl/avr_cpu_reg_writer.sv
// Write-side sequencer for the register bank's single 8-bit write port.
// Turns byte and register-pair results into one or two registered byte writes.
module avr_cpu_reg_writer #(
  parameter int ADDR_W       = 5,
  parameter bit EVEN_IS_HIGH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wide,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_data,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [7:0]        rf_in,
  output logic              rf_write,
  output logic              busy,
  output logic              err_odd
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LAST  = 2'd1;
  localparam logic [1:0] ST_PAIR0 = 2'd2;

  logic [1:0]        state_r;
  logic              ready_r;
  logic              busy_r;
  logic              write_r;
  logic              err_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        in_r;
  logic [ADDR_W-1:0] hold_addr_r;
  logic [7:0]        hold_data_r;

  logic              accept_s;
  logic [ADDR_W-1:0] base_s;
  logic [7:0]        first_s;
  logic [7:0]        second_s;
  logic [1:0]        state_nxt_s;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic [7:0]        in_nxt_s;
  logic              err_nxt_s;
  logic [ADDR_W-1:0] hold_addr_nxt_s;
  logic [7:0]        hold_data_nxt_s;

  // Request decode: the even register of a pair is always written first.
  always_comb begin
    accept_s = req_valid & ready_r;
    base_s   = {req_addr[ADDR_W-1:1], 1'b0};
    if (EVEN_IS_HIGH) begin
      first_s  = req_data[15:8];
      second_s = req_data[7:0];
    end else begin
      first_s  = req_data[7:0];
      second_s = req_data[15:8];
    end
  end

  // Next-state and next-output selection.
  always_comb begin
    state_nxt_s     = ST_IDLE;
    addr_nxt_s      = addr_r;
    in_nxt_s        = in_r;
    err_nxt_s       = 1'b0;
    hold_addr_nxt_s = hold_addr_r;
    hold_data_nxt_s = hold_data_r;
    if (accept_s) begin
      if (req_wide) begin
        state_nxt_s     = ST_PAIR0;
        addr_nxt_s      = base_s;
        in_nxt_s        = first_s;
        err_nxt_s       = req_addr[0];
        hold_addr_nxt_s = base_s | {{(ADDR_W-1){1'b0}}, 1'b1};
        hold_data_nxt_s = second_s;
      end else begin
        state_nxt_s = ST_LAST;
        addr_nxt_s  = req_addr;
        in_nxt_s    = req_data[7:0];
      end
    end else begin
      case (state_r)
        // Second byte of a pair goes out regardless of req_valid.
        ST_PAIR0: begin
          state_nxt_s = ST_LAST;
          addr_nxt_s  = hold_addr_r;
          in_nxt_s    = hold_data_r;
        end
        ST_LAST:  state_nxt_s = ST_IDLE;
        ST_IDLE:  state_nxt_s = ST_IDLE;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs; reset drops any pending second byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      write_r     <= 1'b0;
      err_r       <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      in_r        <= 8'd0;
      hold_addr_r <= {ADDR_W{1'b0}};
      hold_data_r <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      ready_r     <= (state_nxt_s != ST_PAIR0);
      busy_r      <= (state_nxt_s != ST_IDLE);
      write_r     <= (state_nxt_s != ST_IDLE);
      err_r       <= err_nxt_s;
      addr_r      <= addr_nxt_s;
      in_r        <= in_nxt_s;
      hold_addr_r <= hold_addr_nxt_s;
      hold_data_r <= hold_data_nxt_s;
    end
  end

  assign req_ready = ready_r;
  assign busy      = busy_r;
  assign rf_write  = write_r;
  assign err_odd   = err_r;
  assign rf_addr   = addr_r;
  assign rf_in     = in_r;

endmodule
